alu_ctrl: RTL and testbench

- Sequencing controller directly upstream of the 16-bit ALU slice array.
- Accepts an opcode and shift amount with a Start/Busy/Done handshake.
- Drives the per-slice control lines and carry-in for a parameterised settle period to cover ripple-carry and shifter delay.
- On completion, issues a result write strobe and latches the Z/C/N/V status flags from the array's chain and MSB signals.

---
 rtl/alu_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// Sequencing controller for the 16-bit ALU slice array: Start/Busy/Done handshake, settle timer, flag capture.
// Optional `ALU_SHIFT_CARRY_EN adds ShC_in so shifts with a non-zero distance load C from the last bit shifted out.
module alu_ctrl #(
  parameter int unsigned SETTLE = 2
) (
`ifdef ALU_SHIFT_CARRY_EN
  input  logic       ShC_in,
`endif
  input  logic       Clock,
  input  logic       nReset,
  input  logic       Start,
  input  logic [3:0] Opcode,
  input  logic [3:0] ShAmt,
  input  logic       FlagEn,
  input  logic       nZ_in,
  input  logic       COut_in,
  input  logic       A_msb,
  input  logic       B_msb,
  input  logic       Res_msb,
  output logic       AND,
  output logic       OR,
  output logic       XOR,
  output logic       NAND,
  output logic       NOR,
  output logic       NOT,
  output logic       SUB,
  output logic       ZeroA,
  output logic       FAOut,
  output logic       ShOut,
  output logic       ShL,
  output logic       ShR,
  output logic       ShB,
  output logic       Sh1,
  output logic       Sh2,
  output logic       Sh4,
  output logic       Sh8,
  output logic       CIn_Slice,
  output logic       Busy,
  output logic       Done,
  output logic       WrEn,
  output logic [3:0] Flags
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_CAPTURE
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NAND = 4'd5,
    OP_NOR  = 4'd6,
    OP_NOT  = 4'd7,
    OP_LSL  = 4'd8,
    OP_LSR  = 4'd9,
    OP_ASR  = 4'd10,
    OP_CMP  = 4'd11,
    OP_ADC  = 4'd12,
    OP_SBC  = 4'd13,
    OP_MOVB = 4'd14,
    OP_NOP  = 4'd15
  } op_e;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  // Flag bit positions within {Z,C,N,V}
  localparam int unsigned FZ = 3;
  localparam int unsigned FC = 2;
  localparam int unsigned FN = 1;
  localparam int unsigned FV = 0;

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [3:0] sh_q, sh_d;
  logic       fen_q, fen_d;
  logic       cy_q, cy_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] flags_upd;
  logic       v_add, v_sub;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      sh_q    <= '0;
      fen_q   <= 1'b0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      fen_q   <= fen_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  // The carry used by ADC/SBC is frozen at the Start edge in cy_q.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sh_d    = sh_q;
    fen_d   = fen_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d    = op_e'(Opcode);
          sh_d    = ShAmt;
          fen_d   = FlagEn;
          cy_d    = flags_q[FC];
          cnt_d   = CNT_LOAD;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
        if (fen_q) begin
          flags_d = flags_upd;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign v_add = (A_msb == B_msb) && (Res_msb != A_msb);
  assign v_sub = (A_msb != B_msb) && (Res_msb != A_msb);

  always_comb begin
    flags_upd = flags_q;
    if (op_q != OP_NOP) begin
      flags_upd[FZ] = ~nZ_in;
      flags_upd[FN] = Res_msb;
      case (op_q)
        OP_ADD, OP_ADC, OP_MOVB: begin
          flags_upd[FC] = COut_in;
          flags_upd[FV] = v_add;
        end
        OP_SUB, OP_CMP, OP_SBC: begin
          flags_upd[FC] = COut_in;
          flags_upd[FV] = v_sub;
        end
`ifdef ALU_SHIFT_CARRY_EN
        OP_LSL, OP_LSR, OP_ASR: begin
          if (sh_q != '0) begin
            flags_upd[FC] = ShC_in;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    AND       = 1'b0;
    OR        = 1'b0;
    XOR       = 1'b0;
    NAND      = 1'b0;
    NOR       = 1'b0;
    NOT       = 1'b0;
    SUB       = 1'b0;
    ZeroA     = 1'b0;
    FAOut     = 1'b0;
    ShOut     = 1'b0;
    ShL       = 1'b0;
    ShR       = 1'b0;
    ShB       = 1'b0;
    Sh1       = 1'b0;
    Sh2       = 1'b0;
    Sh4       = 1'b0;
    Sh8       = 1'b0;
    CIn_Slice = 1'b0;
    if (state_q != S_IDLE) begin
      case (op_q)
        OP_ADD: FAOut = 1'b1;
        OP_SUB, OP_CMP: begin
          FAOut     = 1'b1;
          SUB       = 1'b1;
          CIn_Slice = 1'b1;
        end
        OP_AND:  AND  = 1'b1;
        OP_OR:   OR   = 1'b1;
        OP_XOR:  XOR  = 1'b1;
        OP_NAND: NAND = 1'b1;
        OP_NOR:  NOR  = 1'b1;
        OP_NOT:  NOT  = 1'b1;
        OP_LSL: begin
          ShOut = 1'b1;
          ShL   = 1'b1;
          {Sh8, Sh4, Sh2, Sh1} = sh_q;
        end
        OP_LSR: begin
          ShOut = 1'b1;
          ShR   = 1'b1;
          {Sh8, Sh4, Sh2, Sh1} = sh_q;
        end
        OP_ASR: begin
          ShOut = 1'b1;
          ShR   = 1'b1;
          ShB   = 1'b1;
          {Sh8, Sh4, Sh2, Sh1} = sh_q;
        end
        OP_ADC: begin
          FAOut     = 1'b1;
          CIn_Slice = cy_q;
        end
        OP_SBC: begin
          FAOut     = 1'b1;
          SUB       = 1'b1;
          CIn_Slice = cy_q;
        end
        OP_MOVB: begin
          FAOut = 1'b1;
          ZeroA = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy  = (state_q != S_IDLE);
  assign Done  = (state_q == S_CAPTURE);
  assign WrEn  = Done && (op_q != OP_CMP) && (op_q != OP_NOP);
  assign Flags = flags_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: directed ops push expectations, a negedge monitor pops on Done.
module tb_alu_ctrl;

  localparam int unsigned SETTLE = 2;

  localparam logic [17:0] B_AND  = 18'h20000;
  localparam logic [17:0] B_OR   = 18'h10000;
  localparam logic [17:0] B_XOR  = 18'h08000;
  localparam logic [17:0] B_NAND = 18'h04000;
  localparam logic [17:0] B_NOR  = 18'h02000;
  localparam logic [17:0] B_NOT  = 18'h01000;
  localparam logic [17:0] B_SUB  = 18'h00800;
  localparam logic [17:0] B_ZA   = 18'h00400;
  localparam logic [17:0] B_FA   = 18'h00200;
  localparam logic [17:0] B_SHO  = 18'h00100;
  localparam logic [17:0] B_SHL  = 18'h00080;
  localparam logic [17:0] B_SHR  = 18'h00040;
  localparam logic [17:0] B_SHB  = 18'h00020;
  localparam logic [17:0] B_SH1  = 18'h00010;
  localparam logic [17:0] B_SH2  = 18'h00008;
  localparam logic [17:0] B_SH4  = 18'h00004;
  localparam logic [17:0] B_SH8  = 18'h00002;
  localparam logic [17:0] B_CIN  = 18'h00001;

  typedef struct {
    string       name;
    logic [17:0] ctrl;
    logic        wr;
    logic [3:0]  fl;
  } exp_t;

  logic       Clock, nReset, Start, FlagEn, nZ_in, COut_in, A_msb, B_msb, Res_msb;
  logic [3:0] Opcode, ShAmt;
`ifdef ALU_SHIFT_CARRY_EN
  logic       ShC;
`endif
  logic w_and, w_or, w_xor, w_nand, w_nor, w_not, w_sub, w_za, w_fa, w_sho, w_shl, w_shr, w_shb;
  logic w_sh1, w_sh2, w_sh4, w_sh8, w_cin, Busy, Done, WrEn;
  logic [3:0] Flags;
  logic [17:0] ctrl_o;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   resolved = 0;

  alu_ctrl #(.SETTLE(SETTLE)) dut (
`ifdef ALU_SHIFT_CARRY_EN
    .ShC_in(ShC),
`endif
    .Clock(Clock), .nReset(nReset), .Start(Start), .Opcode(Opcode), .ShAmt(ShAmt),
    .FlagEn(FlagEn), .nZ_in(nZ_in), .COut_in(COut_in), .A_msb(A_msb), .B_msb(B_msb),
    .Res_msb(Res_msb),
    .AND(w_and), .OR(w_or), .XOR(w_xor), .NAND(w_nand), .NOR(w_nor), .NOT(w_not),
    .SUB(w_sub), .ZeroA(w_za), .FAOut(w_fa), .ShOut(w_sho), .ShL(w_shl), .ShR(w_shr),
    .ShB(w_shb), .Sh1(w_sh1), .Sh2(w_sh2), .Sh4(w_sh4), .Sh8(w_sh8),
    .CIn_Slice(w_cin), .Busy(Busy), .Done(Done), .WrEn(WrEn), .Flags(Flags)
  );

  assign ctrl_o = {w_and, w_or, w_xor, w_nand, w_nor, w_not, w_sub, w_za, w_fa, w_sho,
                   w_shl, w_shr, w_shb, w_sh1, w_sh2, w_sh4, w_sh8, w_cin};

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  initial begin
    int       busy_run;
    int       wait_cyc;
    bit       pend;
    logic [3:0] pend_fl;
    string    pend_nm;
    busy_run = 0;
    wait_cyc = 0;
    pend     = 1'b0;
    pend_fl  = '0;
    pend_nm  = "";
    forever begin
      @(negedge Clock);
      if (!nReset) begin
        busy_run = 0;
        chk("reset_ctrl", 32'(ctrl_o), 32'd0);
        chk("reset_status", 32'({Busy, Done, WrEn, Flags}), 32'd0);
      end else begin
        if (pend) begin
          chk({pend_nm, "_flags"}, 32'(Flags), 32'(pend_fl));
          pend = 1'b0;
        end
        busy_run = Busy ? busy_run + 1 : 0;
        if (q.size() > 0) begin
          wait_cyc++;
          if (Busy) chk({q[0].name, "_ctrl"}, 32'(ctrl_o), 32'(q[0].ctrl));
          if (Done) begin
            chk({q[0].name, "_wren"}, 32'(WrEn), 32'(q[0].wr));
            chk({q[0].name, "_latency"}, 32'(busy_run), 32'(SETTLE + 1));
            pend    = 1'b1;
            pend_fl = q[0].fl;
            pend_nm = q[0].name;
            void'(q.pop_front());
            wait_cyc = 0;
            resolved++;
          end else if (wait_cyc > 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no Done want Done within 20 cycles", q[0].name);
            void'(q.pop_front());
            wait_cyc = 0;
            resolved++;
          end
        end else if (Done || WrEn) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done: got Done=%0b WrEn=%0b want 0 0", Done, WrEn);
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] op, input logic [3:0] sh,
                       input logic fen, input logic nz, input logic co, input logic am,
                       input logic bm, input logic rm, input logic [17:0] ctrl,
                       input logic wr, input logic [3:0] fl, input bit poke);
    exp_t e;
    int   prev;
    e.name = nm;
    e.ctrl = ctrl;
    e.wr   = wr;
    e.fl   = fl;
    q.push_back(e);
    prev    = resolved;
    Opcode  = op;
    ShAmt   = sh;
    FlagEn  = fen;
    nZ_in   = nz;
    COut_in = co;
    A_msb   = am;
    B_msb   = bm;
    Res_msb = rm;
    Start   = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    if (poke) begin
      @(posedge Clock); #1;
      Start  = 1'b1;
      Opcode = 4'd2;
      ShAmt  = 4'hF;
      @(posedge Clock); #1;
      Start = 1'b0;
    end
    for (int i = 0; i < 40 && resolved == prev; i++) begin
      @(posedge Clock); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nReset = 1'b1; Start = 1'b0; Opcode = '0; ShAmt = '0; FlagEn = 1'b0;
    nZ_in = 1'b0; COut_in = 1'b0; A_msb = 1'b0; B_msb = 1'b0; Res_msb = 1'b0;
`ifdef ALU_SHIFT_CARRY_EN
    ShC = 1'b0;
`endif
    #2 nReset = 1'b0;
    repeat (2) @(posedge Clock);
    #1 nReset = 1'b1;

    //     name     op     sh     fen   nz    co    A     B     R     ctrl                                   wr    flags    poke
    issue("add",   4'd0,  4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, B_FA,                                  1'b1, 4'b0011, 1'b0);
    issue("sub",   4'd1,  4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, B_FA|B_SUB|B_CIN,                      1'b1, 4'b1100, 1'b0);
    issue("cmp",   4'd11, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, B_FA|B_SUB|B_CIN,                      1'b0, 4'b0011, 1'b0);
    issue("lsr",   4'd9,  4'hA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, B_SHO|B_SHR|B_SH2|B_SH8,              1'b1, 4'b0001, 1'b0);
    issue("add_poke", 4'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, B_FA,                                1'b1, 4'b0001, 1'b1);
    repeat (4) @(posedge Clock);
    #1;
    issue("add_c", 4'd0,  4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, B_FA,                                  1'b1, 4'b0101, 1'b0);
    issue("adc",   4'd12, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, B_FA|B_CIN,                            1'b1, 4'b1100, 1'b0);
    issue("sbc",   4'd13, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, B_FA|B_SUB|B_CIN,                      1'b1, 4'b0001, 1'b0);
    issue("nand",  4'd5,  4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, B_NAND,                                1'b1, 4'b0011, 1'b0);
    issue("nop",   4'd15, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 18'h0,                                 1'b0, 4'b0011, 1'b0);
    issue("movb",  4'd14, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, B_FA|B_ZA,                             1'b1, 4'b1000, 1'b0);
    issue("asr0",  4'd10, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, B_SHO|B_SHR|B_SHB,                     1'b1, 4'b0010, 1'b0);
    issue("lsl15", 4'd8,  4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, B_SHO|B_SHL|B_SH1|B_SH2|B_SH4|B_SH8,   1'b1, 4'b1000, 1'b0);
    issue("add_c2", 4'd0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, B_FA,                                  1'b1, 4'b0100, 1'b0);

    // ADC aborted by reset mid-EXEC; nothing queued, so any Done/WrEn is spurious.
    Opcode = 4'd12; ShAmt = '0; FlagEn = 1'b1;
    nZ_in = 1'b1; COut_in = 1'b1; A_msb = 1'b0; B_msb = 1'b0; Res_msb = 1'b0;
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    @(posedge Clock); #3;
    nReset = 1'b0;
    @(posedge Clock); #1;
    nReset = 1'b1;

    issue("adc_after_rst", 4'd12, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, B_FA,                          1'b1, 4'b0011, 1'b0);
    repeat (3) @(posedge Clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
